prio_enc_scan: RTL

Parametrised priority encoder with debounced switch inputs, a registered index/valid result and a time-multiplexed multi-digit seven-segment readout. It is the next-generation switch-to-display block for the board front panel. It generalises the fixed 8-input, lowest-bit-wins encoder to N inputs with selectable priority direction, adds input synchronisation and debounce, and scans DIGITS hex digits.

---
 rtl/prio_enc_pkg.sv | 35 +++
 rtl/hex_to_seg7.sv | 14 +
 rtl/prio_enc_scan.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/prio_enc_pkg.sv
// Shared constants and helpers for the front-panel switch priority encoder:
// hex font, dash/decimal-point patterns and fixed-width priority search functions.
package prio_enc_pkg;

  localparam int MAX_N     = 256;
  localparam int MAX_IDX_W = 8;

  localparam logic [7:0] SEG_DASH = 8'h40;
  localparam logic [7:0] SEG_DP   = 8'h80;

  // Element 0 is the rightmost entry, so HEX_FONT[d] is the pattern for digit d.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [MAX_IDX_W:0] enc_lsb(input logic [MAX_N-1:0] vec);
    logic [MAX_IDX_W:0] res;
    res = '0;
    for (int i = MAX_N - 1; i >= 0; i--) begin
      res = vec[i] ? {1'b1, MAX_IDX_W'(i)} : res;
    end
    return res;
  endfunction

  function automatic logic [MAX_IDX_W:0] enc_msb(input logic [MAX_N-1:0] vec);
    logic [MAX_IDX_W:0] res;
    res = '0;
    for (int i = 0; i < MAX_N; i++) begin
      res = vec[i] ? {1'b1, MAX_IDX_W'(i)} : res;
    end
    return res;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Nibble to active-high seven-segment pattern (bit0=a .. bit6=g).
module hex_to_seg7
  import prio_enc_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // font lookup
  always_comb begin
    seg = HEX_FONT[nib];
  end

endmodule

// File: rtl/prio_enc_scan.sv
// Debounced N-input priority encoder with registered index/valid and a
// time-multiplexed hex readout of the winning index.
module prio_enc_scan
  import prio_enc_pkg::*;
#(
  parameter int N        = 16,
  parameter int IDX_W    = $clog2(N),
  parameter int DEBOUNCE = 1000,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      sw,
  input  logic              en,
  input  logic              msb_first,
  output logic [IDX_W-1:0]  idx_o,
  output logic              valid_o,
  output logic              change_o,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int CNT_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int EXT_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DIGITS - 1);

  logic [N-1:0]         sync1_r;
  logic [N-1:0]         s_r;
  logic [N-1:0]         p_r;
  logic [N-1:0]         stable_r;
  logic [CNT_W-1:0]     cnt_r;
  logic [PRE_W-1:0]     pre_r;
  logic [PTR_W-1:0]     ptr_r;

  logic [MAX_IDX_W:0]   enc_s;
  logic [IDX_W-1:0]     idx_next_s;
  logic                 valid_next_s;
  logic [EXT_W-1:0]     ext_s;
  logic [3:0]           nib_s;
  logic [6:0]           font_s;
  logic [7:0]           seg_s;
  logic [DIGITS-1:0]    an_s;

  // two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= '0;
      s_r     <= '0;
    end else begin
      sync1_r <= sw;
      s_r     <= sync1_r;
    end
  end

  // debounce: any change restarts the hold count; counter saturates at the last value
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_r      <= '0;
      cnt_r    <= '0;
      stable_r <= '0;
    end else if (s_r != p_r) begin
      p_r   <= s_r;
      cnt_r <= '0;
    end else if (cnt_r != CNT_LAST) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      stable_r <= p_r;
    end
  end

  // priority search on the committed vector, gated by enable
  always_comb begin
    enc_s = msb_first ? enc_msb(MAX_N'(stable_r)) : enc_lsb(MAX_N'(stable_r));
    if (en) begin
      idx_next_s   = IDX_W'(enc_s[MAX_IDX_W-1:0]);
      valid_next_s = enc_s[MAX_IDX_W];
    end else begin
      idx_next_s   = '0;
      valid_next_s = 1'b0;
    end
  end

  // result register; change flags the same edge the result moves
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_o    <= '0;
      valid_o  <= 1'b0;
      change_o <= 1'b0;
    end else begin
      idx_o    <= idx_next_s;
      valid_o  <= valid_next_s;
      change_o <= ({valid_next_s, idx_next_s} != {valid_o, idx_o});
    end
  end

  // digit-slot prescaler and digit pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_r <= '0;
      ptr_r <= '0;
    end else if (pre_r == PRE_LAST) begin
      pre_r <= '0;
      ptr_r <= (ptr_r == PTR_LAST) ? '0 : ptr_r + PTR_W'(1);
    end else begin
      pre_r <= pre_r + PRE_W'(1);
    end
  end

  // select the scanned nibble and build the segment pattern
  always_comb begin
    ext_s = EXT_W'(idx_o);
    nib_s = 4'h0;
    an_s  = '0;
    for (int k = 0; k < DIGITS; k++) begin
      nib_s   = (ptr_r == PTR_W'(k)) ? ext_s[4*k +: 4] : nib_s;
      an_s[k] = (ptr_r == PTR_W'(k));
    end
    seg_s = valid_o ? {1'b0, font_s} : SEG_DASH;
    seg_s = ((ptr_r == '0) && msb_first) ? (seg_s | SEG_DP) : seg_s;
  end

  hex_to_seg7 u_font (
    .nib (nib_s),
    .seg (font_s)
  );

  // registered display drive
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg_o <= 8'h00;
      an_o  <= '0;
    end else begin
      seg_o <= seg_s;
      an_o  <= an_s;
    end
  end

endmodule
